// File: rtl/bf16_pkg.sv
// Shared BF16 types and constants for the FMA datapath (multiplier and adder).
package bf16_pkg;

  localparam int unsigned BF16_BIAS    = 127;
  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;

  // Operand classification; denormals are folded into ZERO.
  typedef enum logic [2:0] {
    ZERO,
    NORM,
    INF,
    QNAN,
    SNAN
  } bf16_class_e;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] mant;
  } bf16_t;

  // Exception flags travelling with every result; the adder emits the same set.
  typedef struct packed {
    logic zero;
    logic underflow;
    logic overflow;
    logic qnan;
    logic snan;
    logic pos_inf;
    logic neg_inf;
  } bf16_flags_t;

  function automatic bf16_class_e bf16_classify(input bf16_t x);
    if (x.exp == 8'h00)         return ZERO;
    if (x.exp != BF16_EXP_MAX)  return NORM;
    if (x.mant == 7'h00)        return INF;
    if (x.mant[6])              return QNAN;
    return SNAN;
  endfunction

endpackage

// File: rtl/bf16_round_pack.sv
// Combinational normalise / round / pack of a raw 8x8 mantissa product.
// Flushes results below min normal to signed zero and saturates to inf.
module bf16_round_pack
  import bf16_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1
) (
  input  logic              sign_i,
  input  logic [15:0]       prod_i,
  input  logic signed [9:0] exp_i,
  output bf16_t             result_o,
  output bf16_flags_t       flags_o
);

  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_rnd;
  logic [6:0]        mant;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [7:0]        mant_rnd;

  // Normalise the 1.x / 1x.x product, round to 7 bits, then range-check the exponent.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, or a latch is inferred.
    result_o = '0;
    flags_o  = '0;

    if (prod_i[15]) begin
      exp_norm = exp_i + 10'sd1;
      mant     = prod_i[14:8];
      guard    = prod_i[7];
      sticky   = |prod_i[6:0];
    end else begin
      exp_norm = exp_i;
      mant     = prod_i[13:7];
      guard    = prod_i[6];
      sticky   = |prod_i[5:0];
    end

    round_up = ROUND_NEAREST && guard && (sticky || mant[0]);
    mant_rnd = {1'b0, mant} + {7'd0, round_up};
    // A carry out of the 7-bit mantissa leaves mant_rnd[6:0] == 0 and bumps the exponent.
    exp_rnd  = mant_rnd[7] ? exp_norm + 10'sd1 : exp_norm;

    if (exp_rnd >= 10'sd255) begin
      result_o         = '{sign: sign_i, exp: BF16_EXP_MAX, mant: 7'h00};
      flags_o.overflow = 1'b1;
      flags_o.pos_inf  = !sign_i;
      flags_o.neg_inf  = sign_i;
    end else if (exp_rnd <= 10'sd0) begin
      result_o          = '{sign: sign_i, exp: 8'h00, mant: 7'h00};
      flags_o.underflow = 1'b1;
      flags_o.zero      = 1'b1;
    end else begin
      result_o = '{sign: sign_i, exp: exp_rnd[7:0], mant: mant_rnd[6:0]};
    end
  end

endmodule

// File: rtl/bf16_mul_pipe.sv
// Three-stage BF16 multiplier: classify, multiply, normalise/round/pack.
// One global enable stalls every stage together when the adder backpressures.
module bf16_mul_pipe
  import bf16_pkg::*;
#(
  parameter bit ROUND_NEAREST = 1'b1,
  parameter bit FLUSH_DENORM  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        zero,
  output logic        underflow,
  output logic        overflow,
  output logic        qNaN,
  output logic        sNaN,
  output logic        positive_inf,
  output logic        negative_inf
);

  // Denormal inputs/outputs are always flushed; no gradual-underflow path exists.
  if (!FLUSH_DENORM) begin : g_param_check
    $error("bf16_mul_pipe: only FLUSH_DENORM=1 is supported");
  end

  logic en;

  // Stage 1: classified operands
  logic        v1_q;
  logic        sign1_q;
  bf16_class_e cls_a_q, cls_b_q;
  logic [7:0]  exp_a_q, exp_b_q;
  logic [7:0]  man_a_q, man_b_q;

  // Stage 2: raw product plus a pre-selected special result
  logic              v2_q;
  logic              sign2_q;
  logic [15:0]       prod2_q;
  logic signed [9:0] exp2_q;
  logic              spec2_q;
  bf16_t             spec_res2_q;
  bf16_flags_t       spec_flags2_q;

  logic              spec_d;
  bf16_t             spec_res_d;
  bf16_flags_t       spec_flags_d;
  logic [15:0]       prod_d;
  logic signed [9:0] exp_sum_d;

  // Stage 3: registered outputs
  logic        out_valid_q;
  bf16_t       result_q;
  bf16_flags_t flags_q;

  bf16_t       rp_result;
  bf16_flags_t rp_flags;

  bf16_t op_a, op_b;
  assign op_a = num1;
  assign op_b = num2;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  // Stage 1 valid bit; bubbles advance with valid=0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
    if (!rst_n) v1_q <= 1'b0;
    else if (en) v1_q <= in_valid;
  end

  // Stage 1 datapath: classify operands and prepend the implicit one.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are left unreset; only the valid bits decide whether their contents matter.
    if (en && in_valid) begin
      sign1_q <= op_a.sign ^ op_b.sign;
      cls_a_q <= bf16_classify(op_a);
      cls_b_q <= bf16_classify(op_b);
      exp_a_q <= op_a.exp;
      exp_b_q <= op_b.exp;
      man_a_q <= {1'b1, op_a.mant};
      man_b_q <= {1'b1, op_b.mant};
    end
  end

  assign prod_d    = {8'd0, man_a_q} * {8'd0, man_b_q};
  assign exp_sum_d = $signed({2'b00, exp_a_q}) + $signed({2'b00, exp_b_q})
                   - $signed(10'(BF16_BIAS));

  // Select the special-case result (NaN, inf, zero) that overrides the arithmetic path.
  always_comb begin
    logic any_nan, any_snan, inf_zero;
    spec_d       = 1'b0;
    spec_res_d   = '0;
    spec_flags_d = '0;

    any_snan = (cls_a_q == SNAN) || (cls_b_q == SNAN);
    any_nan  = any_snan || (cls_a_q == QNAN) || (cls_b_q == QNAN);
    inf_zero = ((cls_a_q == INF) && (cls_b_q == ZERO)) ||
               ((cls_a_q == ZERO) && (cls_b_q == INF));

    if (any_nan || inf_zero) begin
      spec_d            = 1'b1;
      spec_res_d        = BF16_QNAN;
      spec_flags_d.qnan = 1'b1;
      spec_flags_d.snan = any_snan;
    end else if ((cls_a_q == INF) || (cls_b_q == INF)) begin
      spec_d               = 1'b1;
      spec_res_d           = '{sign: sign1_q, exp: BF16_EXP_MAX, mant: 7'h00};
      spec_flags_d.pos_inf = !sign1_q;
      spec_flags_d.neg_inf = sign1_q;
    end else if ((cls_a_q == ZERO) || (cls_b_q == ZERO)) begin
      spec_d            = 1'b1;
      spec_res_d        = '{sign: sign1_q, exp: 8'h00, mant: 7'h00};
      spec_flags_d.zero = 1'b1;
    end
  end

  // Stage 2 valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) v2_q <= 1'b0;
    else if (en) v2_q <= v1_q;
  end

  // Stage 2 datapath: mantissa product, biased exponent sum, special selection.
  always_ff @(posedge clk) begin
    if (en && v1_q) begin
      sign2_q       <= sign1_q;
      prod2_q       <= prod_d;
      exp2_q        <= exp_sum_d;
      spec2_q       <= spec_d;
      spec_res2_q   <= spec_res_d;
      spec_flags2_q <= spec_flags_d;
    end
  end

  bf16_round_pack #(
    .ROUND_NEAREST (ROUND_NEAREST)
  ) u_round_pack (
    .sign_i   (sign2_q),
    .prod_i   (prod2_q),
    .exp_i    (exp2_q),
    .result_o (rp_result),
    .flags_o  (rp_flags)
  );

  // Stage 3: register the packed result and flags; held stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        result_q <= spec2_q ? spec_res2_q   : rp_result;
        flags_q  <= spec2_q ? spec_flags2_q : rp_flags;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign zero         = flags_q.zero;
  assign underflow    = flags_q.underflow;
  assign overflow     = flags_q.overflow;
  assign qNaN         = flags_q.qnan;
  assign sNaN         = flags_q.snan;
  assign positive_inf = flags_q.pos_inf;
  assign negative_inf = flags_q.neg_inf;

endmodule
